// File: rtl/coprocessor_pkg.sv
// Shared definitions for the column reducer and its float adder:
// reducer state encodings, float32 field constants and small
// field-inspection helpers.
package coprocessor_pkg;

    localparam int FLOAT_W = 32;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;

    localparam logic [EXP_W-1:0]   EXP_ALL_ONES   = 8'hFF;
    localparam logic [FLOAT_W-1:0] FLOAT_POS_ZERO = 32'h0000_0000;
    localparam logic [FLOAT_W-1:0] FLOAT_QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } reducer_state_t;

    // True for +0 and -0: everything except the sign bit is zero.
    function automatic logic is_zero_mag(input logic [FLOAT_W-2:0] mag);
        return (mag == '0);
    endfunction

    // True for Inf and NaN exponents.
    function automatic logic exp_all_ones(input logic [EXP_W-1:0] e);
        return (e == EXP_ALL_ONES);
    endfunction

endpackage

// File: rtl/adder.sv
// Handshake float32 adder.
// Captures a and b when both strobes are high while idle, computes the
// rounded (nearest-even) sum, then presents it on z with z_stb held until
// z_ack. rst is synchronous and active-high.
// Ports: clk, rst, a/a_stb, b/b_stb (operands), z/z_stb/z_ack (result).
module adder
    import coprocessor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOAT_W-1:0] a,
    input  logic               a_stb,
    input  logic [FLOAT_W-1:0] b,
    input  logic               b_stb,
    output logic [FLOAT_W-1:0] z,
    output logic               z_stb,
    input  logic               z_ack
);

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_CALC   = 2'd1,
        A_RESULT = 2'd2
    } add_state_t;

    add_state_t         state_r, state_next;
    logic [FLOAT_W-1:0] op_a_r, op_b_r, sum;

    logic             sa, sb, a_big, sign_big, eff_sub;
    logic             a_nan, b_nan, a_inf, b_inf, round_up;
    logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff, e_big, e_small, e_diff, e_field;
    logic [MAN_W:0]   ma, mb, m_big, m_small;
    logic [53:0]      shifted;
    logic [26:0]      ext_big, ext_small, norm;
    logic [27:0]      mag;
    logic [9:0]       e_res;
    logic [24:0]      rounded;

    // Operand capture, result register and handshake state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= A_IDLE;
            op_a_r  <= '0;
            op_b_r  <= '0;
            z       <= '0;
        end else begin
            state_r <= state_next;
            if (state_r == A_IDLE && a_stb && b_stb) begin
                op_a_r <= a;
                op_b_r <= b;
            end
            if (state_r == A_CALC) begin
                z <= sum;
            end
        end
    end

    // Handshake sequencing.
    always_comb begin
        state_next = state_r;
        z_stb      = 1'b0;
        case (state_r)
            A_IDLE: begin
                if (a_stb && b_stb) state_next = A_CALC;
                else                state_next = A_IDLE;
            end
            A_CALC: state_next = A_RESULT;
            A_RESULT: begin
                z_stb = 1'b1;
                if (z_ack) state_next = A_IDLE;
                else       state_next = A_RESULT;
            end
            default: state_next = A_IDLE;
        endcase
    end

    // Float32 addition: align, add/subtract magnitudes, normalise, round.
    always_comb begin
        sa     = op_a_r[FLOAT_W-1];
        sb     = op_b_r[FLOAT_W-1];
        ea     = op_a_r[FLOAT_W-2 -: EXP_W];
        eb     = op_b_r[FLOAT_W-2 -: EXP_W];
        a_nan  = exp_all_ones(ea) && (op_a_r[MAN_W-1:0] != '0);
        b_nan  = exp_all_ones(eb) && (op_b_r[MAN_W-1:0] != '0);
        a_inf  = exp_all_ones(ea) && (op_a_r[MAN_W-1:0] == '0);
        b_inf  = exp_all_ones(eb) && (op_b_r[MAN_W-1:0] == '0);
        ma     = {ea != 8'd0, op_a_r[MAN_W-1:0]};
        mb     = {eb != 8'd0, op_b_r[MAN_W-1:0]};
        // Denormals share the exponent of the smallest normal.
        ea_eff = (ea == 8'd0) ? 8'd1 : ea;
        eb_eff = (eb == 8'd0) ? 8'd1 : eb;

        // Bits 30:0 order floats by magnitude, so this picks the larger operand.
        a_big    = (op_a_r[FLOAT_W-2:0] >= op_b_r[FLOAT_W-2:0]);
        sign_big = a_big ? sa : sb;
        e_big    = a_big ? ea_eff : eb_eff;
        e_small  = a_big ? eb_eff : ea_eff;
        m_big    = a_big ? ma : mb;
        m_small  = a_big ? mb : ma;
        eff_sub  = sa ^ sb;
        e_diff   = e_big - e_small;

        // Three guard bits; the lowest one collects everything shifted out.
        ext_big = {m_big, 3'b000};
        shifted = {m_small, 3'b000, 27'd0} >> e_diff;
        if (e_diff > 8'd26) ext_small = {26'd0, m_small != 24'd0};
        else                ext_small = {shifted[53:28], shifted[27] | (shifted[26:0] != 27'd0)};

        mag = eff_sub ? ({1'b0, ext_big} - {1'b0, ext_small})
                      : ({1'b0, ext_big} + {1'b0, ext_small});

        e_res = {2'b00, e_big};
        if (mag[27]) begin
            norm  = {mag[27:2], mag[1] | mag[0]};
            e_res = e_res + 10'd1;
        end else begin
            norm  = mag[26:0];
        end
        // Left-normalise after cancellation, stopping at the denormal floor.
        for (int i = 0; i < 26; i++) begin
            if (!norm[26] && (e_res > 10'd1)) begin
                norm  = {norm[25:0], 1'b0};
                e_res = e_res - 10'd1;
            end else begin
                norm  = norm;
                e_res = e_res;
            end
        end

        round_up = norm[2] && (norm[1] || norm[0] || norm[3]);
        rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (rounded[24]) begin
            rounded = {1'b0, rounded[24:1]};
            e_res   = e_res + 10'd1;
        end else begin
            rounded = rounded;
        end
        e_field = rounded[23] ? e_res[7:0] : 8'd0;

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) sum = FLOAT_QNAN;
        else if (a_inf)                                    sum = op_a_r;
        else if (b_inf)                                    sum = op_b_r;
        else if (mag == 28'd0)                             sum = {sa & sb, 31'd0};
        else if (e_res >= 10'd255)                         sum = {sign_big, EXP_ALL_ONES, 23'd0};
        else                                               sum = {sign_big, e_field, rounded[22:0]};
    end

endmodule

// File: rtl/column_reducer.sv
// Column reducer: sums the first in_len float32 cells of in_col through a
// single handshake adder, optionally seeded with the previous result.
// Zero cells (+0/-0) are skipped without using the adder.
// Optional feature macro COLUMN_REDUCER_NAN_DETECT_EN: adds out_flag, set
// when an adder result is Inf/NaN, which also ends the job early.
// Ports:
//   in_clk, in_reset      clock, synchronous active-high reset
//   in_col, in_len        column cells and number of cells to sum (clamped)
//   in_accumulate         seed with current out_cell (1) or +0 (0)
//   in_ready              request strobe, accepted in IDLE only
//   out_ack               result consumed, honoured in DONE only
//   out_busy, out_ready   not idle / result valid
//   out_cell              accumulated sum
//   out_flag              (macro only) Inf/NaN result seen
module column_reducer
    import coprocessor_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int CELL_WIDTH = 32,
    parameter int CNT_W      = $clog2(SIZE + 1)
) (
    input  logic                       in_clk,
    input  logic                       in_reset,
    input  logic [SIZE*CELL_WIDTH-1:0] in_col,
    input  logic [CNT_W-1:0]           in_len,
    input  logic                       in_accumulate,
    input  logic                       in_ready,
    input  logic                       out_ack,
    output logic                       out_busy,
    output logic                       out_ready,
    output logic [CELL_WIDTH-1:0]      out_cell
`ifdef COLUMN_REDUCER_NAN_DETECT_EN
    ,
    output logic                       out_flag
`endif
);

    reducer_state_t             state_r, state_next;
    logic [SIZE*CELL_WIDTH-1:0] col_r;
    logic [CNT_W-1:0]           len_r, index_r, len_clamped;
    logic [CELL_WIDTH-1:0]      acc_r, cur_cell, add_z;
    logic                       busy_r, ready_r;
    logic                       add_stb, add_z_stb, add_z_ack, add_rst, cur_zero, nan_hit;

    assign len_clamped = (in_len > CNT_W'(SIZE)) ? CNT_W'(SIZE) : in_len;
    assign cur_zero    = is_zero_mag(cur_cell[CELL_WIDTH-2:0]);
    assign add_rst     = (state_r == IDLE) || (state_r == DONE);
    assign out_busy    = busy_r;
    assign out_ready   = ready_r;
    assign out_cell    = acc_r;

`ifdef COLUMN_REDUCER_NAN_DETECT_EN
    assign nan_hit = exp_all_ones(add_z[CELL_WIDTH-2 -: EXP_W]);
`else
    assign nan_hit = 1'b0;
`endif

    // Select the cell at the current index.
    always_comb begin
        cur_cell = '0;
        for (int i = 0; i < SIZE; i++) begin
            cur_cell = (index_r == CNT_W'(i)) ? col_r[i*CELL_WIDTH +: CELL_WIDTH] : cur_cell;
        end
    end

    // Next state and adder handshake. The strobes stay high from LOAD through
    // ADD; the adder only samples them while it is idle.
    always_comb begin
        state_next = state_r;
        add_stb    = 1'b0;
        add_z_ack  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_ready) state_next = LOAD;
                else          state_next = IDLE;
            end
            LOAD: begin
                if (index_r == len_r) begin
                    state_next = DONE;
                end else if (cur_zero) begin
                    state_next = LOAD;
                end else begin
                    add_stb    = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                add_stb = 1'b1;
                if (add_z_stb) begin
                    add_z_ack  = 1'b1;
                    state_next = nan_hit ? DONE : LOAD;
                end else begin
                    state_next = ADD;
                end
            end
            DONE: begin
                if (out_ack) state_next = IDLE;
                else         state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Job registers, accumulator and registered status outputs.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_r <= IDLE;
            col_r   <= '0;
            len_r   <= '0;
            index_r <= '0;
            acc_r   <= FLOAT_POS_ZERO;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next;
            busy_r  <= (state_next != IDLE);
            ready_r <= (state_next == DONE);
            case (state_r)
                IDLE: begin
                    if (in_ready) begin
                        col_r   <= in_col;
                        len_r   <= len_clamped;
                        index_r <= '0;
                        acc_r   <= in_accumulate ? acc_r : FLOAT_POS_ZERO;
                    end
                end
                LOAD: begin
                    if (index_r != len_r && cur_zero) index_r <= index_r + CNT_W'(1);
                end
                ADD: begin
                    if (add_z_stb) begin
                        acc_r   <= add_z;
                        index_r <= index_r + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef COLUMN_REDUCER_NAN_DETECT_EN
    logic flag_r;

    // Sticky Inf/NaN flag, cleared when the next request is accepted.
    always_ff @(posedge in_clk) begin
        if (in_reset)                                   flag_r <= 1'b0;
        else if (state_r == IDLE && in_ready)           flag_r <= 1'b0;
        else if (state_r == ADD && add_z_stb && nan_hit) flag_r <= 1'b1;
        else                                            flag_r <= flag_r;
    end

    assign out_flag = flag_r;
`endif

    adder u_adder (
        .clk   (in_clk),
        .rst   (add_rst),
        .a     (cur_cell),
        .a_stb (add_stb),
        .b     (acc_r),
        .b_stb (add_stb),
        .z     (add_z),
        .z_stb (add_z_stb),
        .z_ack (add_z_ack)
    );

endmodule
